axis_frame_writer: RTL and testbench
====================================

Name: axis_frame_writer

Overview:
- Parametrised successor to the stream-to-BRAM converter in the video path.
- Accepts the 8-bit AXI-Stream from the image filter and assembles bytes into pixels, in RGB565 or 8-bit greyscale selected at run time.
- Writes pixels into the frame buffer with an output handshake; supports double-buffered banks, frame-length checking and frame counting.
- Sits between the filter stage and the frame-buffer BRAM / VGA reader.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, pixel address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- CH_W, 5, output width per colour channel, 1..8; channels take their source MSBs
- DOUBLE_BUF, 1, 1 = toggle write bank on every good frame; 0 = bank fixed at 0

Ports:
- clk  in  1  system clock; single clock domain
- RESET  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; sampled only at frame boundaries
- fmt  in  1  0 = RGB565 (2 bytes per pixel, first byte is MSB); 1 = grey8 (1 byte per pixel); sampled at frame start
- s_tdata  in  8  stream byte
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- s_tlast  in  1  last byte of frame
- red, green, blue  out  CH_W each  pixel channels
- index  out  ADDR_W  pixel address within bank
- wr_bank  out  1  bank of the current write
- valid  out  1  write request
- wr_ready  in  1  memory accepts the write when valid && wr_ready
- rd_bank  out  1  bank holding the last complete frame
- frame_done  out  1  one-cycle pulse on a good frame
- frame_err  out  1  one-cycle pulse on a bad frame
- frame_count  out  16  count of good frames; wraps 65535 -> 0

Behaviour:
- Reset values:
  - All outputs 0, except s_tready = 1.
  - State IDLE; byte phase 0; index, wr_bank and rd_bank all 0.
- Handshakes:
  - An input beat is accepted when s_tvalid && s_tready.
  - s_tready = !valid || wr_ready (single output register; no combinational path from s_tdata to outputs).
  - valid, index and the channel outputs stay stable while valid && !wr_ready.
- Latency: a pixel appears on the outputs the cycle after its final byte is accepted.
- Colour mapping:
  - RGB565: R = p[15:11], G = p[10:5], B = p[4:0]. Each channel is left-aligned to 8 bits with zero fill, then its top CH_W bits are taken. With CH_W = 5: G = p[10:6].
  - grey8: R = G = B = byte[7:8-CH_W].
- States:
  - IDLE: consumes and discards beats. It moves to RUN on the first accepted beat after a frame boundary, and only if enable = 1. That beat is processed as pixel data. Frame boundary means reset, or the beat after an accepted tlast.
  - RUN: assembles pixels. index starts at 0 and increments by 1 after each pixel write is accepted. fmt is latched on entry.
  - DRAIN: discards beats until tlast is accepted, then goes to IDLE.
- Good frame: tlast arrives on the final byte of pixel H_RES*V_RES-1. Required response:
  - frame_done pulses.
  - frame_count increments.
  - rd_bank is set to wr_bank.
  - If DOUBLE_BUF = 1, wr_bank toggles.
  - index returns to 0; state goes to IDLE.
- Early tlast (fewer pixels, or odd byte phase in RGB565):
  - A partial pixel is dropped.
  - frame_err pulses; index resets to 0.
  - Bank and counter are unchanged; state goes to IDLE.
- Overrun (pixel H_RES*V_RES-1 completes without tlast):
  - The last pixel is still written.
  - State goes to DRAIN; frame_err pulses when the drain ends. Bank and counter are unchanged.
- tlast asserted in IDLE: treated as a frame boundary only.
- enable falling mid-frame: the current frame completes normally; the block then stays in IDLE.
- RESET mid-frame: everything returns to reset values immediately, including dropping a pending valid.

Decomposition:
- Shared package video_pkg holds:
  - FMT_RGB565 = 0 and FMT_GREY8 = 1
  - the state encoding (IDLE, RUN, DRAIN)
  - a function computing FRAME_PIX = H_RES*V_RES
- One natural sub-module, pixel_packer: byte-phase tracking, 565/grey unpacking and the output register with the valid/wr_ready hold.
- The frame FSM, address counter, banks and frame counter live in the top.

Test Plan (H_RES = 4, V_RES = 2, CH_W = 5, DOUBLE_BUF = 1 unless stated):
- RGB565, 16 bytes, each pixel = 0xF81F, tlast on byte 16, wr_ready = 1.
  -> 8 writes, index 0..7, R = 31, G = 0, B = 31, wr_bank = 0.
  -> frame_done pulses once; rd_bank = 0, wr_bank becomes 1, frame_count = 1.
- grey8, 8 bytes 0x00..0xE0 step 0x20, with wr_ready held low for 3 cycles on pixel 2.
  -> s_tready low during the stall; pixel-2 outputs held stable.
  -> R = G = B = byte >> 3, index 0..7, no beats lost.
- RGB565, tlast on byte 7 (odd phase).
  -> 3 writes, frame_err pulses, partial pixel dropped.
  -> frame_count and wr_bank unchanged; next frame writes from index 0.
- RGB565, 20 bytes, tlast on byte 20.
  -> 8 writes, then DRAIN of 4 beats with s_tready = 1.
  -> frame_err pulses at tlast; no frame_done.
- enable = 0 at frame start.
  -> whole frame discarded, valid never asserted, s_tready = 1 throughout.
  -> Then enable = 1 for the next frame -> normal capture.
- Three good frames with DOUBLE_BUF = 0.
  -> wr_bank = rd_bank = 0 throughout, frame_count = 3.
  -> RESET asserted mid-fourth frame -> all outputs 0 and s_tready = 1 asynchronously.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video capture path: pixel formats, frame FSM
// state encoding and frame-size helper.
package video_pkg;

  // Run-time pixel format select
  localparam logic FMT_RGB565 = 1'b0;
  localparam logic FMT_GREY8  = 1'b1;

  // Frame FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Number of pixels in one complete frame
  function automatic int frame_pix(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

endpackage

// File: rtl/pixel_packer.sv
// Byte-to-pixel packer: tracks the byte phase inside a pixel, unpacks
// RGB565 or grey8 into CH_W-bit channels and holds the single output
// register (pixel, address, bank) until the memory accepts it.
module pixel_packer
  import video_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int CH_W   = 5
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              beat,      // accepted beat that carries pixel data
  input  logic [7:0]        data,
  input  logic              last,
  input  logic              fmt,
  input  logic [ADDR_W-1:0] addr,
  input  logic              bank,
  input  logic              wr_ready,
  output logic              pix_done,  // this beat completes a pixel
  output logic              ready,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic [ADDR_W-1:0] index,
  output logic              wr_bank,
  output logic              valid
);

  // Top CH_W bits of a left-aligned 8-bit channel
  function automatic logic [CH_W-1:0] msbs(input logic [7:0] v);
    return v[7 -: CH_W];
  endfunction

  logic        phase_r;   // 1 = high byte of an RGB565 pixel already held
  logic [7:0]  hi_r;
  logic [15:0] pix_s;
  logic [7:0]  r8_s;
  logic [7:0]  g8_s;
  logic [7:0]  b8_s;

  // Only one output register: a new pixel may load whenever the held one
  // is gone or leaves on this same edge.
  assign ready = !valid || wr_ready;

  // Pixel completion and channel unpacking, each channel left-aligned to 8 bits
  always_comb begin
    pix_s    = {hi_r, data};
    pix_done = beat && ((fmt == FMT_GREY8) || phase_r);
    if (fmt == FMT_GREY8) begin
      r8_s = data;
      g8_s = data;
      b8_s = data;
    end else begin
      r8_s = {pix_s[15:11], 3'b000};
      g8_s = {pix_s[10:5],  2'b00};
      b8_s = {pix_s[4:0],   3'b000};
    end
  end

  // Byte phase; a tlast on a high byte drops the partial pixel
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      phase_r <= 1'b0;
      hi_r    <= 8'd0;
    end else if (beat) begin
      hi_r <= data;
      if ((fmt == FMT_GREY8) || phase_r || last) begin
        phase_r <= 1'b0;
      end else begin
        phase_r <= 1'b1;
      end
    end
  end

  // Output register: load a completed pixel, hold while stalled, clear on accept
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      valid   <= 1'b0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      index   <= '0;
      wr_bank <= 1'b0;
    end else if (pix_done) begin
      valid   <= 1'b1;
      red     <= msbs(r8_s);
      green   <= msbs(g8_s);
      blue    <= msbs(b8_s);
      index   <= addr;
      wr_bank <= bank;
    end else if (wr_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_frame_writer.sv
// AXI-Stream to frame-buffer writer. Frame FSM, pixel address counter,
// write/read bank selection and good-frame counter; pixel assembly and the
// output register live in pixel_packer.
module axis_frame_writer
  import video_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int CH_W       = 5,
  parameter int DOUBLE_BUF = 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              fmt,
  input  logic [7:0]        s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic [ADDR_W-1:0] index,
  output logic              wr_bank,
  output logic              valid,
  input  logic              wr_ready,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count
);

  localparam int FRAME_PIX = frame_pix(H_RES, V_RES);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIX - 1);

  state_t            state_r;
  logic              fmt_r;
  logic              boundary_r;   // next accepted beat starts a frame
  logic [ADDR_W-1:0] pix_cnt_r;    // address of the next pixel to assemble
  logic              bank_r;       // bank the current/next frame writes to
  logic              rd_bank_r;
  logic              frame_done_r;
  logic              frame_err_r;
  logic [15:0]       frame_count_r;

  logic              fire_s;
  logic              start_s;
  logic              process_s;
  logic              cur_fmt_s;
  logic              pix_done_s;
  logic              last_pix_s;
  logic              good_s;
  logic              early_s;
  logic              overrun_s;
  logic              drain_end_s;
  logic              pk_ready_s;
  logic              pk_valid_s;
  logic              pk_bank_s;
  logic [ADDR_W-1:0] pk_index_s;

  // Frame-level decode of the current beat
  always_comb begin
    fire_s      = s_tvalid && s_tready;
    start_s     = (state_r == IDLE) && fire_s && boundary_r && enable;
    process_s   = start_s || ((state_r == RUN) && fire_s);
    cur_fmt_s   = start_s ? fmt : fmt_r;
    last_pix_s  = pix_done_s && (pix_cnt_r == LAST_PIX);
    good_s      = process_s && s_tlast && last_pix_s;
    early_s     = process_s && s_tlast && !last_pix_s;
    overrun_s   = process_s && !s_tlast && last_pix_s;
    drain_end_s = (state_r == DRAIN) && fire_s && s_tlast;
  end

  pixel_packer #(
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_packer (
    .clk      (clk),
    .RESET    (RESET),
    .beat     (process_s),
    .data     (s_tdata),
    .last     (s_tlast),
    .fmt      (cur_fmt_s),
    .addr     (pix_cnt_r),
    .bank     (bank_r),
    .wr_ready (wr_ready),
    .pix_done (pix_done_s),
    .ready    (pk_ready_s),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .index    (pk_index_s),
    .wr_bank  (pk_bank_s),
    .valid    (pk_valid_s)
  );

  assign s_tready    = pk_ready_s;
  assign valid       = pk_valid_s;
  assign rd_bank     = rd_bank_r;
  assign frame_done  = frame_done_r;
  assign frame_err   = frame_err_r;
  assign frame_count = frame_count_r;

  // A pending write carries its own captured address and bank so the frame
  // bookkeeping may move on underneath it; with nothing pending the next
  // write position is shown.
  assign index   = pk_valid_s ? pk_index_s : pix_cnt_r;
  assign wr_bank = pk_valid_s ? pk_bank_s  : bank_r;

  // Frame FSM with address counter, banks, frame counter and status pulses
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_r       <= IDLE;
      fmt_r         <= FMT_RGB565;
      boundary_r    <= 1'b1;
      pix_cnt_r     <= '0;
      bank_r        <= 1'b0;
      rd_bank_r     <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      frame_done_r <= good_s;
      frame_err_r  <= early_s || drain_end_s;

      if (fire_s) begin
        boundary_r <= s_tlast;
      end

      if (start_s) begin
        fmt_r <= fmt;
      end

      case (state_r)
        IDLE, RUN: begin
          if (process_s) begin
            if (s_tlast) begin
              state_r <= IDLE;
            end else if (last_pix_s) begin
              state_r <= DRAIN;
            end else begin
              state_r <= RUN;
            end
          end
        end
        DRAIN: begin
          if (drain_end_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (good_s || early_s || overrun_s) begin
        pix_cnt_r <= '0;
      end else if (pix_done_s) begin
        pix_cnt_r <= pix_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end

      if (good_s) begin
        frame_count_r <= frame_count_r + 16'd1;
        rd_bank_r     <= bank_r;
        if (DOUBLE_BUF != 0) begin
          bank_r <= ~bank_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_writer.sv
// Directed bench for axis_frame_writer with a 4x2 frame. Instance 0 is
// double-buffered, instance 1 single-buffered; sel chooses which one the
// driver and monitor follow.
module tb_axis_frame_writer;

  localparam int AW = 3;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, enable, fmt, s_tvalid, s_tlast, wr_ready, sel;
  logic [7:0] s_tdata;

  logic          tr0, v0, wb0, rb0, fd0, fe0, tr1, v1, wb1, rb1, fd1, fe1;
  logic [CW-1:0] r0, g0, b0, r1, g1, b1;
  logic [AW-1:0] i0, i1;
  logic [15:0]   fc0, fc1;

  axis_frame_writer #(.H_RES(4), .V_RES(2), .ADDR_W(AW), .CH_W(CW), .DOUBLE_BUF(1)) dut0 (
    .clk(clk), .RESET(rst0), .enable(enable), .fmt(fmt), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(tr0), .s_tlast(s_tlast), .red(r0), .green(g0),
    .blue(b0), .index(i0), .wr_bank(wb0), .valid(v0), .wr_ready(wr_ready),
    .rd_bank(rb0), .frame_done(fd0), .frame_err(fe0), .frame_count(fc0));

  axis_frame_writer #(.H_RES(4), .V_RES(2), .ADDR_W(AW), .CH_W(CW), .DOUBLE_BUF(0)) dut1 (
    .clk(clk), .RESET(rst1), .enable(enable), .fmt(fmt), .s_tdata(s_tdata),
    .s_tvalid(s_tvalid), .s_tready(tr1), .s_tlast(s_tlast), .red(r1), .green(g1),
    .blue(b1), .index(i1), .wr_bank(wb1), .valid(v1), .wr_ready(wr_ready),
    .rd_bank(rb1), .frame_done(fd1), .frame_err(fe1), .frame_count(fc1));

  logic          m_tready, m_valid, m_wb, m_rb, m_fd, m_fe;
  logic [CW-1:0] m_r, m_g, m_b;
  logic [AW-1:0] m_idx;
  logic [15:0]   m_fc;

  assign m_tready = sel ? tr1 : tr0;
  assign m_valid  = sel ? v1  : v0;
  assign m_wb     = sel ? wb1 : wb0;
  assign m_rb     = sel ? rb1 : rb0;
  assign m_fd     = sel ? fd1 : fd0;
  assign m_fe     = sel ? fe1 : fe0;
  assign m_r      = sel ? r1  : r0;
  assign m_g      = sel ? g1  : g0;
  assign m_b      = sel ? b1  : b0;
  assign m_idx    = sel ? i1  : i0;
  assign m_fc     = sel ? fc1 : fc0;

  typedef struct {
    int idx;
    int r;
    int g;
    int b;
    int bank;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  valid_cycles = 0;
  int  checks = 0;
  int  errors = 0;

  // Monitor: records every write that the next rising edge will complete
  always @(negedge clk) begin
    wr_t e;
    #2;
    if (m_valid && wr_ready) begin
      e.idx = int'(m_idx); e.r = int'(m_r); e.g = int'(m_g); e.b = int'(m_b); e.bank = int'(m_wb);
      wq.push_back(e);
    end
    if (m_fd) done_cnt++;
    if (m_fe) err_cnt++;
    if (m_valid) valid_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Offer one byte (from a falling edge) until accepted; returns cycles waited
  task automatic send_byte(input logic [7:0] d, input logic last, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (m_tready) done = 1'b1;
      else waited++;
      @(negedge clk);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %h not accepted, required acceptance within 40 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; sel = 1'b0; enable = 1'b1; fmt = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; wr_ready = 1'b1;
    #12;
    checks++;
    if (m_tready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: tready=%b valid=%b required 1 0", m_tready, m_valid);
    end
    checks++;
    if (m_idx !== 3'd0 || m_wb !== 1'b0 || m_rb !== 1'b0 || m_fc !== 16'd0) begin
      errors++; $display("FAIL reset_regs: index=%0d wr_bank=%b rd_bank=%b count=%0d required all 0", m_idx, m_wb, m_rb, m_fc);
    end
    checks++;
    if (m_r !== 5'd0 || m_g !== 5'd0 || m_b !== 5'd0 || m_fd !== 1'b0 || m_fe !== 1'b0) begin
      errors++; $display("FAIL reset_pix: rgb=%0d/%0d/%0d done=%b err=%b required 0", m_r, m_g, m_b, m_fd, m_fe);
    end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rgb_good();
    int base, d0, e0, w;
    base = wq.size(); d0 = done_cnt; e0 = err_cnt;
    fmt = 1'b0;
    for (int i = 0; i < 16; i++) send_byte((i % 2 == 0) ? 8'hF8 : 8'h1F, i == 15, w);
    idle(4);
    checks++;
    if (wq.size() - base !== 8) begin
      errors++; $display("FAIL rgb_writes: got %0d writes, required 8", wq.size() - base);
    end
    for (int i = 0; i < 8; i++) begin
      if (base + i < wq.size()) begin
        checks++;
        if (wq[base+i].idx !== i || wq[base+i].r !== 31 || wq[base+i].g !== 0 || wq[base+i].b !== 31 || wq[base+i].bank !== 0) begin
          errors++; $display("FAIL rgb_pix%0d: idx=%0d rgb=%0d/%0d/%0d bank=%0d required %0d 31/0/31 0", i,
                             wq[base+i].idx, wq[base+i].r, wq[base+i].g, wq[base+i].b, wq[base+i].bank, i);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL rgb_pulses: done=%0d err=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if (m_rb !== 1'b0 || m_wb !== 1'b1 || m_fc !== 16'd1 || m_idx !== 3'd0) begin
      errors++; $display("FAIL rgb_state: rd_bank=%b wr_bank=%b count=%0d index=%0d required 0 1 1 0", m_rb, m_wb, m_fc, m_idx);
    end
  endtask

  task automatic test_grey_stall();
    int base, d0, w;
    base = wq.size(); d0 = done_cnt;
    fmt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i * 32), i == 7, w);
      if (i == 2) begin
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          checks++;
          if (m_tready !== 1'b0 || m_valid !== 1'b1 || m_idx !== 3'd2 || m_r !== 5'd8 || m_g !== 5'd8 || m_b !== 5'd8) begin
            errors++; $display("FAIL stall_hold%0d: tready=%b valid=%b idx=%0d rgb=%0d/%0d/%0d required 0 1 2 8/8/8",
                               k, m_tready, m_valid, m_idx, m_r, m_g, m_b);
          end
          @(negedge clk);
        end
        wr_ready = 1'b1;
      end
    end
    idle(4);
    checks++;
    if (wq.size() - base !== 8) begin
      errors++; $display("FAIL grey_writes: got %0d writes, required 8", wq.size() - base);
    end
    for (int i = 0; i < 8; i++) begin
      if (base + i < wq.size()) begin
        checks++;
        if (wq[base+i].idx !== i || wq[base+i].r !== 4*i || wq[base+i].g !== 4*i || wq[base+i].b !== 4*i || wq[base+i].bank !== 1) begin
          errors++; $display("FAIL grey_pix%0d: idx=%0d rgb=%0d/%0d/%0d bank=%0d required %0d %0d 1", i,
                             wq[base+i].idx, wq[base+i].r, wq[base+i].g, wq[base+i].b, wq[base+i].bank, i, 4*i);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || m_fc !== 16'd2 || m_rb !== 1'b1 || m_wb !== 1'b0) begin
      errors++; $display("FAIL grey_state: done=%0d count=%0d rd_bank=%b wr_bank=%b required 1 2 1 0", done_cnt - d0, m_fc, m_rb, m_wb);
    end
  endtask

  task automatic test_early_tlast();
    int base, d0, e0, w;
    base = wq.size(); d0 = done_cnt; e0 = err_cnt;
    fmt = 1'b0;
    for (int i = 0; i < 7; i++) send_byte((i % 2 == 0) ? 8'h07 : 8'hE0, i == 6, w);
    idle(4);
    checks++;
    if (wq.size() - base !== 3) begin
      errors++; $display("FAIL early_writes: got %0d writes, required 3", wq.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      if (base + i < wq.size()) begin
        checks++;
        if (wq[base+i].idx !== i || wq[base+i].r !== 0 || wq[base+i].g !== 31 || wq[base+i].b !== 0 || wq[base+i].bank !== 0) begin
          errors++; $display("FAIL early_pix%0d: idx=%0d rgb=%0d/%0d/%0d bank=%0d required %0d 0/31/0 0", i,
                             wq[base+i].idx, wq[base+i].r, wq[base+i].g, wq[base+i].b, wq[base+i].bank, i);
        end
      end
    end
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || m_fc !== 16'd2 || m_wb !== 1'b0 || m_idx !== 3'd0) begin
      errors++; $display("FAIL early_state: err=%0d done=%0d count=%0d wr_bank=%b index=%0d required 1 0 2 0 0",
                         err_cnt - e0, done_cnt - d0, m_fc, m_wb, m_idx);
    end
  endtask

  task automatic test_overrun();
    int base, d0, e0, w;
    base = wq.size(); d0 = done_cnt; e0 = err_cnt;
    fmt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_byte((i % 2 == 0) ? 8'hF8 : 8'h00, i == 19, w);
      if (i >= 16) begin
        checks++;
        if (w !== 0) begin
          errors++; $display("FAIL drain_ready%0d: waited %0d cycles, required 0", i, w);
        end
      end
    end
    idle(4);
    checks++;
    if (wq.size() - base !== 8) begin
      errors++; $display("FAIL over_writes: got %0d writes, required 8", wq.size() - base);
    end
    for (int i = 0; i < 8; i++) begin
      if (base + i < wq.size()) begin
        checks++;
        if (wq[base+i].idx !== i || wq[base+i].r !== 31 || wq[base+i].g !== 0 || wq[base+i].b !== 0 || wq[base+i].bank !== 0) begin
          errors++; $display("FAIL over_pix%0d: idx=%0d rgb=%0d/%0d/%0d bank=%0d required %0d 31/0/0 0", i,
                             wq[base+i].idx, wq[base+i].r, wq[base+i].g, wq[base+i].b, wq[base+i].bank, i);
        end
      end
    end
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || m_fc !== 16'd2 || m_rb !== 1'b1 || m_wb !== 1'b0) begin
      errors++; $display("FAIL over_state: err=%0d done=%0d count=%0d rd_bank=%b wr_bank=%b required 1 0 2 1 0",
                         err_cnt - e0, done_cnt - d0, m_fc, m_rb, m_wb);
    end
  endtask

  task automatic test_enable();
    int base, d0, e0, vc0, w, wsum;
    base = wq.size(); d0 = done_cnt; e0 = err_cnt; vc0 = valid_cycles; wsum = 0;
    fmt = 1'b1; enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'hFF, i == 7, w);
      wsum += w;
    end
    idle(3);
    checks++;
    if (wq.size() - base !== 0 || valid_cycles - vc0 !== 0 || wsum !== 0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL disabled: writes=%0d valid_cycles=%0d stalls=%0d done=%0d err=%0d required all 0",
                         wq.size() - base, valid_cycles - vc0, wsum, done_cnt - d0, err_cnt - e0);
    end
    enable = 1'b1;
    base = wq.size();
    for (int i = 0; i < 8; i++) send_byte(8'h9C, i == 7, w);
    idle(4);
    checks++;
    if (wq.size() - base !== 8) begin
      errors++; $display("FAIL enable_writes: got %0d writes, required 8", wq.size() - base);
    end
    for (int i = 0; i < 8; i++) begin
      if (base + i < wq.size()) begin
        checks++;
        if (wq[base+i].idx !== i || wq[base+i].r !== 19 || wq[base+i].g !== 19 || wq[base+i].b !== 19 || wq[base+i].bank !== 0) begin
          errors++; $display("FAIL enable_pix%0d: idx=%0d rgb=%0d/%0d/%0d bank=%0d required %0d 19/19/19 0", i,
                             wq[base+i].idx, wq[base+i].r, wq[base+i].g, wq[base+i].b, wq[base+i].bank, i);
        end
      end
    end
    checks++;
    if (done_cnt - d0 !== 1 || m_fc !== 16'd3 || m_wb !== 1'b1 || m_rb !== 1'b0) begin
      errors++; $display("FAIL enable_state: done=%0d count=%0d wr_bank=%b rd_bank=%b required 1 3 1 0", done_cnt - d0, m_fc, m_wb, m_rb);
    end
  endtask

  task automatic test_single_buf_reset();
    int base, d0, w, badbank;
    sel = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    base = wq.size(); d0 = done_cnt;
    fmt = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) send_byte(8'h40, i == 7, w);
      idle(3);
      checks++;
      if (m_wb !== 1'b0 || m_rb !== 1'b0 || m_fc !== 16'(f + 1)) begin
        errors++; $display("FAIL single_frame%0d: wr_bank=%b rd_bank=%b count=%0d required 0 0 %0d", f, m_wb, m_rb, m_fc, f + 1);
      end
    end
    badbank = 0;
    for (int i = base; i < wq.size(); i++) if (wq[i].bank !== 0 || wq[i].r !== 8) badbank++;
    checks++;
    if (wq.size() - base !== 24 || badbank !== 0 || done_cnt - d0 !== 3) begin
      errors++; $display("FAIL single_writes: writes=%0d bad=%0d done=%0d required 24 0 3", wq.size() - base, badbank, done_cnt - d0);
    end
    send_byte(8'h40, 1'b0, w);
    send_byte(8'h40, 1'b0, w);
    wr_ready = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_tready !== 1'b0 || m_idx !== 3'd1) begin
      errors++; $display("FAIL pre_reset: valid=%b tready=%b index=%0d required 1 0 1", m_valid, m_tready, m_idx);
    end
    #2;
    rst1 = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_tready !== 1'b1 || m_idx !== 3'd0 || m_fc !== 16'd0 || m_wb !== 1'b0 || m_rb !== 1'b0) begin
      errors++; $display("FAIL async_reset: valid=%b tready=%b index=%0d count=%0d banks=%b%b required 0 1 0 0 00",
                         m_valid, m_tready, m_idx, m_fc, m_wb, m_rb);
    end
    checks++;
    if (m_r !== 5'd0 || m_g !== 5'd0 || m_b !== 5'd0 || m_fd !== 1'b0 || m_fe !== 1'b0) begin
      errors++; $display("FAIL async_reset_pix: rgb=%0d/%0d/%0d done=%b err=%b required 0", m_r, m_g, m_b, m_fd, m_fe);
    end
    @(negedge clk);
    rst1 = 1'b0;
    wr_ready = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_rgb_good();
    test_grey_stall();
    test_early_tlast();
    test_overrun();
    test_enable();
    test_single_buf_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
